rx_msg_buffer: RTL

Receive-side buffer directly downstream of `uart_rx`, in the `clk_3125_rx` domain. Captures each received byte on the rising edge of `rx_complete`, checks it against `rx_parity`, and stores good bytes in a circular FIFO. Counts complete messages delimited by a terminator byte. Exposes a read handshake and sticky error status to the consuming logic.

---
 rtl/rx_buf_pkg.sv | 18 +
 rtl/rx_buf_mem.sv | 30 +++
 rtl/rx_msg_buffer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/rx_buf_pkg.sv
// Shared types, defaults and the parity check for the receive message buffer.
package rx_buf_pkg;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CHECK = 1'b1
  } rxb_state_e;

  localparam int unsigned RXB_DEPTH = 16;
  localparam logic [7:0]  RXB_TERM  = 8'h23;

  // odd = 0 selects even parity, odd = 1 selects odd parity; returns 1 on failure
  function automatic logic parity_bad(input logic [7:0] msg, input logic par,
                                      input logic odd);
    return (^{msg, par}) ^ odd;
  endfunction

endpackage

// File: rtl/rx_buf_mem.sv
// DEPTH x 8 storage with one write port and one registered read port.
module rx_buf_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [7:0]    i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_data
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)      r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/rx_msg_buffer.sv
// Receive-side byte FIFO behind uart_rx: edge capture, parity check, message
// counting on terminator bytes, and sticky error reporting.
module rx_msg_buffer
  import rx_buf_pkg::*;
#(
  parameter int unsigned DEPTH    = RXB_DEPTH,
  parameter logic [7:0]  TERM     = RXB_TERM,
  parameter bit          DROP_BAD = 1'b1
) (
  input  logic                     clk_3125_rx,
  input  logic                     reset,
  input  logic                     parity_type,
  input  logic [7:0]               rx_msg,
  input  logic                     rx_parity,
  input  logic                     rx_complete,
  input  logic                     rd_en,
  input  logic                     clear_err,
  output logic [7:0]               rb_out,
  output logic                     rb_valid,
  output logic                     rb_empty,
  output logic                     rb_full,
  output logic [$clog2(DEPTH):0]   rb_count,
  output logic                     msg_ready,
  output logic                     parity_err,
  output logic                     overflow,
  output logic [7:0]               err_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  rxb_state_e    r_state, w_state_nxt;
  logic          r_rxc_q, r_hold_par, w_latch;
  logic [7:0]    r_hold_msg;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count, r_msgs, w_count_nxt, w_msgs_nxt;
  logic [DEPTH-1:0] r_term;
  logic          r_valid, r_empty, r_full, r_msg_ready, r_par_err, r_ovf;
  logic [7:0]    r_err_count, w_err_base, w_err_nxt;
  logic          w_capture, w_in_check, w_bad, w_store, w_full;
  logic          w_wr, w_ovf, w_rd, w_term_wr, w_term_rd;

  assign w_capture  = rx_complete && !r_rxc_q;
  assign w_in_check = (r_state == S_CHECK);

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE:  if (w_capture) begin
                 w_latch     = 1'b1;
                 w_state_nxt = S_CHECK;
               end
      S_CHECK: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Full is judged on pre-read occupancy, so a same-cycle read never frees room
  assign w_bad     = w_in_check && parity_bad(r_hold_msg, r_hold_par, parity_type);
  assign w_store   = w_in_check && !(w_bad && DROP_BAD);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_ovf     = w_store && w_full;
  assign w_wr      = w_store && !w_full;
  assign w_rd      = rd_en && (r_count != '0);
  assign w_term_wr = w_wr && (r_hold_msg == TERM);
  assign w_term_rd = w_rd && r_term[r_rd_ptr];

  assign w_count_nxt = r_count + CW'(w_wr) - CW'(w_rd);
  assign w_msgs_nxt  = r_msgs + CW'(w_term_wr) - CW'(w_term_rd);

  // A new error in the same cycle as clear_err restarts the count at 1
  assign w_err_base = clear_err ? '0 : r_err_count;
  assign w_err_nxt  = ((w_bad || w_ovf) && (w_err_base != 8'hFF)) ? w_err_base + 8'd1
                                                                  : w_err_base;

  always_ff @(posedge clk_3125_rx) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rxc_q     <= 1'b0;
      r_hold_msg  <= '0;
      r_hold_par  <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_msgs      <= '0;
      r_valid     <= 1'b0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_msg_ready <= 1'b0;
      r_par_err   <= 1'b0;
      r_ovf       <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rxc_q     <= rx_complete;
      if (w_latch) begin
        r_hold_msg <= rx_msg;
        r_hold_par <= rx_parity;
      end
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count     <= w_count_nxt;
      r_msgs      <= w_msgs_nxt;
      r_valid     <= w_rd;
      r_empty     <= (w_count_nxt == '0);
      r_full      <= (w_count_nxt == CW'(DEPTH));
      r_msg_ready <= (w_msgs_nxt != '0);
      r_par_err   <= w_bad || (r_par_err && !clear_err);
      r_ovf       <= w_ovf || (r_ovf && !clear_err);
      r_err_count <= w_err_nxt;
    end
  end

  always_ff @(posedge clk_3125_rx) begin
    if (w_wr) r_term[r_wr_ptr] <= (r_hold_msg == TERM);
  end

  rx_buf_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .i_clk     (clk_3125_rx),
    .i_reset   (reset),
    .i_wr_en   (w_wr),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (r_hold_msg),
    .i_rd_en   (w_rd),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (rb_out)
  );

  assign rb_valid   = r_valid;
  assign rb_empty   = r_empty;
  assign rb_full    = r_full;
  assign rb_count   = r_count;
  assign msg_ready  = r_msg_ready;
  assign parity_err = r_par_err;
  assign overflow   = r_ovf;
  assign err_count  = r_err_count;

endmodule
